// File: rtl/host_pkt_buffer_write.sv
// Packs the 9-bit host byte stream into 128-bit packet-buffer lines, claims a buffer ID per packet,
// writes the lines to packet RAM and emits one descriptor per packet; ID-less packets are dropped.
module host_pkt_buffer_write #(
  parameter int MAX_PKT_BYTES = 2048
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [8:0]   iv_data,
  input  logic         i_data_wr,
  input  logic [18:0]  iv_ctrl_data,
  input  logic [8:0]   iv_pkt_bufid,
  input  logic         i_pkt_bufid_wr,
  output logic         o_pkt_bufid_ack,
  output logic [133:0] ov_pkt,
  output logic [15:0]  ov_pkt_addr,
  output logic         o_pkt_wr,
  output logic [39:0]  ov_descriptor,
  output logic         o_descriptor_wr,
  output logic [15:0]  ov_drop_cnt,
  output logic [1:0]   ov_state
);

  localparam int CNT_W = $clog2(MAX_PKT_BYTES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [8:0]         bufid_q, bufid_d;
  logic [18:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [127:0]       line_q, line_d;
  logic [133:0]       pkt_q, pkt_d;
  logic [15:0]        addr_q, addr_d;
  logic               pkt_wr_q, pkt_wr_d;
  logic               ack_q, ack_d;
  logic               desc_pend_q, desc_pend_d;
  logic [39:0]        desc_stage_q, desc_stage_d;
  logic [39:0]        desc_q, desc_d;
  logic               desc_wr_q, desc_wr_d;
  logic [15:0]        drop_q, drop_d;

  logic               head_ok, head_drop, wr_byte, oversize, last_line, flush;
  logic [3:0]         lane;
  logic [6:0]         line_idx;
  logic [CNT_W-1:0]   cnt_next;

  // State register plus all datapath flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      bufid_q      <= '0;
      ctrl_q       <= '0;
      byte_cnt_q   <= '0;
      line_q       <= '0;
      pkt_q        <= '0;
      addr_q       <= '0;
      pkt_wr_q     <= 1'b0;
      ack_q        <= 1'b0;
      desc_pend_q  <= 1'b0;
      desc_stage_q <= '0;
      desc_q       <= '0;
      desc_wr_q    <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      bufid_q      <= bufid_d;
      ctrl_q       <= ctrl_d;
      byte_cnt_q   <= byte_cnt_d;
      line_q       <= line_d;
      pkt_q        <= pkt_d;
      addr_q       <= addr_d;
      pkt_wr_q     <= pkt_wr_d;
      ack_q        <= ack_d;
      desc_pend_q  <= desc_pend_d;
      desc_stage_q <= desc_stage_d;
      desc_q       <= desc_d;
      desc_wr_q    <= desc_wr_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic: any marked byte after the head is the tail.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (i_data_wr && iv_data[8]) state_d = i_pkt_bufid_wr ? ST_WRITE : ST_DISCARD;
      ST_WRITE:   if (wr_byte && iv_data[8]) state_d = ST_IDLE;
                  else if (oversize)         state_d = ST_DISCARD;
      ST_DISCARD: if (i_data_wr && iv_data[8]) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-dependent strobes.
  always_comb begin
    head_ok   = (state_q == ST_IDLE) && i_data_wr && iv_data[8] && i_pkt_bufid_wr;
    head_drop = (state_q == ST_IDLE) && i_data_wr && iv_data[8] && !i_pkt_bufid_wr;
    wr_byte   = (state_q == ST_WRITE) && i_data_wr;
    lane      = byte_cnt_q[3:0];
    line_idx  = byte_cnt_q[10:4];
    cnt_next  = byte_cnt_q + 1'b1;
    oversize  = wr_byte && !iv_data[8] && (cnt_next == CNT_W'(MAX_PKT_BYTES));
    last_line = wr_byte && (iv_data[8] || oversize);
    flush     = wr_byte && ((lane == 4'hF) || iv_data[8]);
  end

  // Datapath: staging line, RAM write register, descriptor pipeline, drop counter.
  // NOTE: every always_comb target gets a default first so no latches are inferred.
  always_comb begin
    bufid_d      = bufid_q;
    ctrl_d       = ctrl_q;
    byte_cnt_d   = byte_cnt_q;
    line_d       = line_q;
    pkt_d        = pkt_q;
    addr_d       = addr_q;
    pkt_wr_d     = 1'b0;
    ack_d        = 1'b0;
    desc_pend_d  = 1'b0;
    desc_stage_d = desc_stage_q;
    desc_d       = desc_q;
    desc_wr_d    = 1'b0;
    drop_d       = drop_q;

    if (head_ok) begin
      bufid_d    = iv_pkt_bufid;
      ctrl_d     = iv_ctrl_data;
      byte_cnt_d = CNT_W'(1);
      line_d     = {iv_data[7:0], 120'b0};
      ack_d      = 1'b1;
    end
    if (head_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if (wr_byte) begin
      byte_cnt_d = cnt_next;
      line_d     = ((lane == 4'd0) ? 128'b0 : line_q) | ({iv_data[7:0], 120'b0} >> {lane, 3'b000});
      if (flush) begin
        // Invalid byte count is 15 - lane, which is zero for a full line.
        pkt_d    = {(line_idx == 7'd0), last_line, ~lane, line_d};
        addr_d   = {bufid_q, line_idx};
        pkt_wr_d = 1'b1;
      end
      if (last_line) begin
        // An exact 2048-byte length wraps to 0 in the 11-bit field.
        desc_pend_d  = 1'b1;
        desc_stage_d = {oversize, ctrl_q, bufid_q, cnt_next[10:0]};
      end
    end

    if (desc_pend_q) begin
      desc_d    = desc_stage_q;
      desc_wr_d = 1'b1;
    end
  end

  assign o_pkt_bufid_ack = ack_q;
  assign ov_pkt          = pkt_q;
  assign ov_pkt_addr     = addr_q;
  assign o_pkt_wr        = pkt_wr_q;
  assign ov_descriptor   = desc_q;
  assign o_descriptor_wr = desc_wr_q;
  assign ov_drop_cnt     = drop_q;
  assign ov_state        = state_q;

endmodule

// File: tb/tb_host_pkt_buffer_write.sv
// Directed bench for host_pkt_buffer_write: table of packets plus hand sequences for
// back-to-back minimum packets, idle ID offers and mid-packet reset.
module tb_host_pkt_buffer_write;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [8:0]   iv_data = '0;
  logic         i_data_wr = 1'b0;
  logic [18:0]  iv_ctrl_data = '0;
  logic [8:0]   iv_pkt_bufid = '0;
  logic         i_pkt_bufid_wr = 1'b0;
  logic         o_pkt_bufid_ack;
  logic [133:0] ov_pkt;
  logic [15:0]  ov_pkt_addr;
  logic         o_pkt_wr;
  logic [39:0]  ov_descriptor;
  logic         o_descriptor_wr;
  logic [15:0]  ov_drop_cnt;
  logic [1:0]   ov_state;

  host_pkt_buffer_write dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_data(iv_data), .i_data_wr(i_data_wr),
    .iv_ctrl_data(iv_ctrl_data), .iv_pkt_bufid(iv_pkt_bufid), .i_pkt_bufid_wr(i_pkt_bufid_wr),
    .o_pkt_bufid_ack(o_pkt_bufid_ack), .ov_pkt(ov_pkt), .ov_pkt_addr(ov_pkt_addr), .o_pkt_wr(o_pkt_wr),
    .ov_descriptor(ov_descriptor), .o_descriptor_wr(o_descriptor_wr), .ov_drop_cnt(ov_drop_cnt),
    .ov_state(ov_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [133:0] pkt;
    logic [15:0]  addr;
    int           cyc;
  } wr_rec_t;

  typedef struct {
    logic [39:0] desc;
    int          cyc;
  } desc_rec_t;

  typedef struct {
    int          nbytes;
    logic [8:0]  id;
    logic [18:0] ctrl;
    bit          offer;
    int          exp_writes;
    int          exp_descs;
    bit          exp_err;
    logic [10:0] exp_len;
    logic [15:0] exp_drop;
    int          exp_acks;
  } vec_t;

  wr_rec_t   wr_q[$];
  desc_rec_t desc_q[$];
  int        ack_cnt = 0;
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from the registers' update.
  always @(negedge i_clk) begin
    if (o_pkt_wr) wr_q.push_back('{ov_pkt, ov_pkt_addr, cyc});
    if (o_descriptor_wr) desc_q.push_back('{ov_descriptor, cyc});
    if (o_pkt_bufid_ack) ack_cnt = ack_cnt + 1;
  end

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [7:0] seed, input int k);
    return 8'(k * 13) + seed;
  endfunction

  // Reference line: bytes stored big-endian within the line, truncated at 2048 bytes.
  function automatic logic [133:0] exp_line(input int n, input int li, input logic [7:0] seed);
    int stored, cnt, last_li;
    logic [127:0] data;
    stored  = (n > 2048) ? 2048 : n;
    last_li = (stored - 1) / 16;
    cnt     = stored - 16 * li;
    if (cnt > 16) cnt = 16;
    data = '0;
    for (int j = 0; j < cnt; j++) data[127 - 8*j -: 8] = byte_of(seed, 16*li + j);
    return {(li == 0), (li == last_li), 4'(16 - cnt), data};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_data_wr      = 1'b0;
      i_pkt_bufid_wr = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic mark, input logic [7:0] b, input bit head,
                            input logic [8:0] id, input logic [18:0] ctrl, input bit offer);
    @(negedge i_clk);
    i_data_wr = 1'b1;
    iv_data   = {mark, b};
    if (head) begin
      iv_ctrl_data   = ctrl;
      iv_pkt_bufid   = id;
      i_pkt_bufid_wr = offer;
    end else begin
      i_pkt_bufid_wr = 1'b0;
    end
  endtask

  task automatic send_pkt(input int n, input logic [8:0] id, input logic [18:0] ctrl,
                          input bit offer, input logic [7:0] seed);
    for (int k = 0; k < n; k++)
      drive_byte((k == 0) || (k == n - 1), byte_of(seed, k), (k == 0), id, ctrl, offer);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    desc_q.delete();
    ack_cnt = 0;
  endtask

  vec_t vecs[7];

  initial begin
    wr_rec_t   w;
    desc_rec_t d;
    logic [7:0] seed;
    int nw;

    vecs[0] = '{64,   9'h005, 19'h1234A, 1'b1, 4,   1, 1'b0, 11'd64, 16'd0, 1};
    vecs[1] = '{17,   9'h00A, 19'h00011, 1'b1, 2,   1, 1'b0, 11'd17, 16'd0, 1};
    vecs[2] = '{60,   9'h00B, 19'h22222, 1'b0, 0,   0, 1'b0, 11'd0,  16'd1, 0};
    vecs[3] = '{2100, 9'h1FF, 19'h7FFFF, 1'b1, 128, 1, 1'b1, 11'd0,  16'd1, 1};
    vecs[4] = '{32,   9'h100, 19'h40001, 1'b1, 2,   1, 1'b0, 11'd32, 16'd1, 1};
    vecs[5] = '{16,   9'h003, 19'h0ABCD, 1'b1, 1,   1, 1'b0, 11'd16, 16'd1, 1};
    vecs[6] = '{2048, 9'h0C0, 19'h55555, 1'b1, 128, 1, 1'b0, 11'd0,  16'd1, 1};

    // Reset state
    #12;
    check("rst_state", ov_state, 2'd0);
    check("rst_pkt_wr", o_pkt_wr, 1'b0);
    check("rst_pkt", ov_pkt, '0);
    check("rst_desc", ov_descriptor, '0);
    check("rst_drop", ov_drop_cnt, 16'd0);
    check("rst_ack", o_pkt_bufid_ack, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);

    // Table-driven packets
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      seed = 8'(v * 31 + 1);
      send_pkt(vecs[v].nbytes, vecs[v].id, vecs[v].ctrl, vecs[v].offer, seed);
      idle(6);
      check($sformatf("v%0d_nwrites", v), wr_q.size(), vecs[v].exp_writes);
      nw = wr_q.size();
      for (int i = 0; i < nw && i < vecs[v].exp_writes; i++) begin
        w = wr_q.pop_front();
        check($sformatf("v%0d_addr%0d", v, i), w.addr, {vecs[v].id, 7'(i)});
        check($sformatf("v%0d_line%0d", v, i), w.pkt, exp_line(vecs[v].nbytes, i, seed));
      end
      check($sformatf("v%0d_ndesc", v), desc_q.size(), vecs[v].exp_descs);
      if (desc_q.size() > 0 && vecs[v].exp_descs > 0) begin
        d = desc_q.pop_front();
        check($sformatf("v%0d_desc", v), d.desc,
              {vecs[v].exp_err, vecs[v].ctrl, vecs[v].id, vecs[v].exp_len});
      end
      check($sformatf("v%0d_acks", v), ack_cnt, vecs[v].exp_acks);
      check($sformatf("v%0d_drop", v), ov_drop_cnt, vecs[v].exp_drop);
      check($sformatf("v%0d_state", v), ov_state, 2'd0);
    end

    // Back-to-back minimum packets, IDs 1..3
    clear_mon();
    for (int p = 1; p <= 3; p++) send_pkt(2, 9'(p), 19'(p * 4096 + 7), 1'b1, 8'(p * 16));
    idle(6);
    check("b2b_nwrites", wr_q.size(), 3);
    check("b2b_ndesc", desc_q.size(), 3);
    check("b2b_acks", ack_cnt, 3);
    if (wr_q.size() == 3 && desc_q.size() == 3) begin
      for (int p = 0; p < 3; p++) begin
        check($sformatf("b2b_addr%0d", p), wr_q[p].addr, {9'(p + 1), 7'd0});
        check($sformatf("b2b_line%0d", p), wr_q[p].pkt, exp_line(2, 0, 8'((p + 1) * 16)));
        check($sformatf("b2b_desc%0d", p), desc_q[p].desc,
              {1'b0, 19'((p + 1) * 4096 + 7), 9'(p + 1), 11'd2});
        check($sformatf("b2b_desc_lat%0d", p), desc_q[p].cyc, wr_q[p].cyc + 1);
        if (p < 2) check($sformatf("b2b_order%0d", p), (desc_q[p].cyc < wr_q[p + 1].cyc), 1'b1);
      end
    end

    // Offered ID without a head, and an unmarked byte in IDLE
    clear_mon();
    @(negedge i_clk);
    iv_pkt_bufid = 9'h007;
    i_pkt_bufid_wr = 1'b1;
    i_data_wr = 1'b0;
    repeat (3) @(negedge i_clk);
    i_data_wr = 1'b1;
    iv_data = {1'b0, 8'hA5};
    idle(4);
    check("noh_acks", ack_cnt, 0);
    check("noh_writes", wr_q.size(), 0);
    check("noh_state", ov_state, 2'd0);

    // Reset in the middle of a 100-byte packet
    clear_mon();
    for (int k = 0; k < 21; k++) drive_byte((k == 0), byte_of(8'h40, k), (k == 0), 9'h033, 19'h01111, 1'b1);
    @(negedge i_clk);
    i_data_wr = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("mrst_state", ov_state, 2'd0);
    check("mrst_pkt", ov_pkt, '0);
    check("mrst_addr", ov_pkt_addr, 16'd0);
    check("mrst_drop", ov_drop_cnt, 16'd0);
    check("mrst_desc", ov_descriptor, '0);
    idle(2);
    i_rst_n = 1'b1;
    idle(3);
    check("mrst_no_desc", desc_q.size(), 0);
    clear_mon();
    send_pkt(20, 9'h044, 19'h02222, 1'b1, 8'h50);
    idle(6);
    check("post_rst_nwrites", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("post_rst_line0", wr_q[0].pkt, exp_line(20, 0, 8'h50));
      check("post_rst_line1", wr_q[1].pkt, exp_line(20, 1, 8'h50));
      check("post_rst_addr1", wr_q[1].addr, {9'h044, 7'd1});
    end
    check("post_rst_ndesc", desc_q.size(), 1);
    if (desc_q.size() == 1) check("post_rst_desc", desc_q[0].desc, {1'b0, 19'h02222, 9'h044, 11'd20});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
